cmac_psum_accum: RTL and testbench
==================================

# cmac_psum_accum

Partial-sum accumulator directly downstream of the CMAC MAC cell. It consumes the per-cycle 22-bit signed dot-product results (`mac_out_data`/`mac_out_pvld`) and sums a configured number of consecutive results, one per channel group, into one signed result. It saturates the result to the output width and presents it through a small output FIFO with a valid/ready handshake toward the accumulation buffer. The MAC side has no backpressure, so FIFO overflow is detected and flagged, never stalled.

## Interface
Clock and reset: one clock; reset is asynchronous and active-high.

Parameters:
- `IN_W`, 22, width of the signed MAC partial sum.
- `ACC_W`, 32, width of the signed output result; the internal accumulator is `ACC_W+1` bits.
- `LEN_W`, 8, width of the accumulation-length field.
- `FIFO_DEPTH`, 4, number of output FIFO entries; must be a power of 2 and at least 2.

Ports:
- `nvdla_core_clk`, in, 1, block clock.
- `nvdla_core_rst`, in, 1, asynchronous active-high reset.
- `cfg_reg_en`, in, 1, single-cycle pulse that latches `cfg_accum_len` and restarts accumulation.
- `cfg_accum_len`, in, LEN_W, accumulation length minus 1 (0 means 1 partial per result).
- `mac_out_pvld`, in, 1, partial-sum valid.
- `mac_out_data`, in, IN_W, signed partial sum.
- `acc_out_pvld`, out, 1, result valid (FIFO non-empty).
- `acc_out_prdy`, in, 1, consumer ready.
- `acc_out_data`, out, ACC_W, signed saturated result.
- `acc_out_sat`, out, 1, the result at the FIFO head was saturated.
- `acc_busy`, out, 1, a partial accumulation is in progress.
- `acc_ovf_err`, out, 1, sticky flag: a result was dropped because the FIFO was full.

## Operation
- States: `IDLE` and `ACCUM`. Reset enters `IDLE`.
  - `IDLE`: on `mac_out_pvld`, load `acc = sext(data)`, set `cnt = 0`, and go to `ACCUM`. If `len_q == 0`, complete immediately and stay in `IDLE`.
  - `ACCUM`: on `mac_out_pvld`, set `acc = acc + sext(data)` and `cnt++`. When `cnt == len_q` (the final partial), complete and return to `IDLE`.
- Complete means:
  - Saturate the `ACC_W+1`-bit sum to the signed `ACC_W` range: above `2^(ACC_W-1)-1` clamps to the maximum, below `-2^(ACC_W-1)` clamps to the minimum, and the `sat` bit is set.
  - Push `{sat, data}` into the FIFO.
- Per-add saturation: if an intermediate add overflows the `ACC_W+1` range, clamp the accumulator and hold a sticky per-result `sat` bit until the result completes. With the default parameters this cannot occur; it is required for reduced `ACC_W`.
- FIFO full at completion: if a pop happens in the same cycle, push normally. Otherwise drop the result and set `acc_ovf_err`. Accumulation continues with the next partial.
- `cfg_reg_en`:
  - Latches `len_q`, discards any partial accumulation, forces `IDLE`, and clears `acc_ovf_err`.
  - FIFO contents are kept.
  - A `mac_out_pvld` in the same cycle is discarded.
- `acc_busy = (state == ACCUM)`.
- Gaps in `mac_out_pvld` are allowed anywhere; the state holds.

## Timing
- Latency: a final partial sampled at edge t sets `acc_out_pvld` and `acc_out_data` from t+1, provided the FIFO was empty or that entry is at the head.
- Handshake:
  - A pop occurs at an edge where `acc_out_pvld & acc_out_prdy` is high.
  - `acc_out_data` and `acc_out_sat` are stable while `acc_out_pvld & !acc_out_prdy`.
- FIFO outputs come from registered storage; there is no combinational path from `mac_out_*` to `acc_out_*`.
- Throughput is 1 partial per cycle, and up to 1 result per cycle when `len_q == 0`.
- Reset values:
  - Outputs: `acc_out_pvld=0`, `acc_out_data=0`, `acc_out_sat=0`, `acc_busy=0`, `acc_ovf_err=0`.
  - Internal: `len_q=0`, FIFO pointers 0, accumulator 0.
- Reset asserted mid-accumulation: the partial sum is lost and the FIFO is emptied asynchronously.
- FIFO pointers are `log2(FIFO_DEPTH)+1` bits.
  - Full: MSBs differ and the rest are equal.
  - Empty: the pointers are equal.
  - Pointers wrap naturally.

## Structure
- Package `cmac_acc_pkg`:
  - State enum `{IDLE, ACCUM}`.
  - Default width constants `IN_W`, `ACC_W`, `LEN_W`.
  - Saturation function `sat_acc(logic signed [ACC_W:0]) -> {sat, data}`.
- Sub-module `cmac_acc_fifo`:
  - Parameterised width (`ACC_W+1`) and depth.
  - Push/pop, full/empty, registered storage, asynchronous active-high reset.
- The top level holds the FSM, counter, accumulator, saturation and error flag.

## Test plan
- Length 4, `acc_out_prdy=1`, partials 100, -30, 7, 1 in consecutive cycles -> one result 78 at t+1 after the last partial; `acc_out_sat=0`; `acc_busy` high for 3 cycles.
- Length 1 (`cfg_accum_len=0`), partials `0x1FFFFF` and `0x200000` (-2097152) back to back -> results 2097151 then -2097152 on consecutive cycles.
- `ACC_W=24`, length 16, each partial `0x1FFFFF` -> result 8388607 with `acc_out_sat=1`; the negative mirror case gives -8388608.
- `acc_out_prdy=0`, length 1, 5 partials -> 4 results held in order, 5th dropped, `acc_ovf_err=1`; then `prdy=1` drains the 4 in order.
- `cfg_reg_en` pulse after 2 of 4 partials, then 4 fresh partials of 1 -> single result 4; `acc_ovf_err` cleared.
- Reset asserted mid-accumulation with 2 results queued -> `acc_out_pvld=0` immediately (asynchronous); the next length-4 burst gives the correct sum.

Source files
------------

// File: rtl/cmac_acc_pkg.sv
// Shared types, default widths and the output saturation helper for the CMAC
// partial-sum accumulator.
package cmac_acc_pkg;

  localparam int unsigned IN_W  = 22;
  localparam int unsigned ACC_W = 32;
  localparam int unsigned LEN_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_e;

  typedef struct packed {
    logic             sat;
    logic [ACC_W-1:0] data;
  } sat_res_t;

  // Clamps to the signed range of `width` bits (width <= ACC_W); result sits in
  // the low `width` bits of data.
  function automatic sat_res_t sat_acc(input logic signed [ACC_W:0] sum,
                                       input int unsigned           width);
    sat_res_t     r;
    longint       v;
    longint       hi;
    longint       lo;
    v  = longint'(sum);
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    r.sat = 1'b0;
    if (v > hi) begin
      v     = hi;
      r.sat = 1'b1;
    end else if (v < lo) begin
      v     = lo;
      r.sat = 1'b1;
    end
    r.data = v[ACC_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/cmac_acc_fifo.sv
// Small registered-storage FIFO; a push into a full FIFO is accepted only when
// a pop happens in the same cycle.
module cmac_acc_fifo #(
  parameter int unsigned Width = 33,
  parameter int unsigned Depth = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [Width-1:0] i_wdata,
  input  logic             i_pop,
  output logic [Width-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(Depth);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [Width-1:0] r_mem [Depth];
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);
  assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < Depth; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        r_wr_ptr                <= r_wr_ptr + (AW + 1)'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/cmac_psum_accum.sv
// Sums a configured number of consecutive MAC partial sums, saturates the result
// and queues it toward the accumulation buffer; overflow drops and flags.
module cmac_psum_accum #(
  parameter int unsigned IN_W       = cmac_acc_pkg::IN_W,
  parameter int unsigned ACC_W      = cmac_acc_pkg::ACC_W,
  parameter int unsigned LEN_W      = cmac_acc_pkg::LEN_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    nvdla_core_clk,
  input  logic                    nvdla_core_rst,
  input  logic                    cfg_reg_en,
  input  logic [LEN_W-1:0]        cfg_accum_len,
  input  logic                    mac_out_pvld,
  input  logic signed [IN_W-1:0]  mac_out_data,
  output logic                    acc_out_pvld,
  input  logic                    acc_out_prdy,
  output logic signed [ACC_W-1:0] acc_out_data,
  output logic                    acc_out_sat,
  output logic                    acc_busy,
  output logic                    acc_ovf_err
);
  import cmac_acc_pkg::*;

  localparam int unsigned PkgW = cmac_acc_pkg::ACC_W + 1;

  acc_state_e              r_state;
  acc_state_e              w_state_nxt;
  logic [LEN_W-1:0]        r_len_q;
  logic [LEN_W-1:0]        r_cnt;
  logic [LEN_W-1:0]        w_cnt_nxt;
  logic [LEN_W-1:0]        w_cnt_inc;
  logic signed [ACC_W:0]   r_acc;
  logic signed [ACC_W:0]   w_acc_nxt;
  logic                    r_sat;
  logic                    w_sat_nxt;
  logic                    r_ovf_err;
  logic signed [ACC_W:0]   w_part_ext;
  logic signed [ACC_W+1:0] w_sum_wide;
  logic signed [ACC_W:0]   w_sum;
  logic                    w_add_ovf;
  logic                    w_complete;
  logic signed [ACC_W:0]   w_res_acc;
  logic                    w_res_sat;
  logic signed [PkgW-1:0]  w_res_ext;
  sat_res_t                w_res;
  logic [ACC_W:0]          w_push_data;
  logic [ACC_W:0]          w_head;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_pop;
  logic                    w_drop;

  assign w_part_ext = {{(ACC_W + 1 - IN_W){mac_out_data[IN_W-1]}}, mac_out_data};
  assign w_cnt_inc  = r_cnt + LEN_W'(1);

  // Intermediate add clamps at the ACC_W+1 range; only reachable for narrow ACC_W.
  always_comb begin
    w_sum_wide = {r_acc[ACC_W], r_acc} + {w_part_ext[ACC_W], w_part_ext};
    w_add_ovf  = (w_sum_wide[ACC_W+1] != w_sum_wide[ACC_W]);
    if (!w_add_ovf) begin
      w_sum = w_sum_wide[ACC_W:0];
    end else if (w_sum_wide[ACC_W+1]) begin
      w_sum = {1'b1, {ACC_W{1'b0}}};
    end else begin
      w_sum = {1'b0, {ACC_W{1'b1}}};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    w_sat_nxt   = r_sat;
    w_complete  = 1'b0;
    w_res_acc   = w_part_ext;
    w_res_sat   = 1'b0;
    if (cfg_reg_en) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_acc_nxt   = '0;
      w_sat_nxt   = 1'b0;
    end else if (mac_out_pvld) begin
      case (r_state)
        IDLE: begin
          w_acc_nxt = w_part_ext;
          w_sat_nxt = 1'b0;
          w_cnt_nxt = '0;
          if (r_len_q == '0) begin
            w_complete = 1'b1;
          end else begin
            w_state_nxt = ACCUM;
          end
        end
        ACCUM: begin
          w_acc_nxt = w_sum;
          w_sat_nxt = r_sat | w_add_ovf;
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == r_len_q) begin
            w_complete  = 1'b1;
            w_res_acc   = w_sum;
            w_res_sat   = r_sat | w_add_ovf;
            w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign w_res_ext   = PkgW'(w_res_acc);
  assign w_res       = sat_acc(w_res_ext, ACC_W);
  assign w_push_data = {w_res.sat | w_res_sat, w_res.data[ACC_W-1:0]};
  assign w_pop       = acc_out_pvld & acc_out_prdy;
  assign w_drop      = w_complete & w_full & ~w_pop;

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      r_state   <= IDLE;
      r_len_q   <= '0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_sat     <= 1'b0;
      r_ovf_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_acc   <= w_acc_nxt;
      r_sat   <= w_sat_nxt;
      if (cfg_reg_en) begin
        r_len_q   <= cfg_accum_len;
        r_ovf_err <= 1'b0;
      end else if (w_drop) begin
        r_ovf_err <= 1'b1;
      end
    end
  end

  cmac_acc_fifo #(
    .Width (ACC_W + 1),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (nvdla_core_clk),
    .i_rst   (nvdla_core_rst),
    .i_push  (w_complete),
    .i_wdata (w_push_data),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign acc_out_pvld = ~w_empty;
  assign acc_out_data = w_head[ACC_W-1:0];
  assign acc_out_sat  = w_head[ACC_W];
  assign acc_busy     = (r_state == ACCUM);
  assign acc_ovf_err  = r_ovf_err;

endmodule

// File: tb/tb_cmac_psum_accum.sv
// Scoreboard bench: a default-width instance and a 24-bit-result instance
// that exercises saturation.
`timescale 1ns/1ps
module tb_cmac_psum_accum;

  typedef struct packed {
    logic               sat;
    logic signed [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic               a_cfg_en = 1'b0, a_pvld = 1'b0, a_prdy = 1'b0;
  logic [7:0]         a_len = '0;
  logic signed [21:0] a_data = '0;
  logic               a_out_pvld, a_out_sat, a_busy, a_ovf;
  logic signed [31:0] a_out_data;

  logic               b_cfg_en = 1'b0, b_pvld = 1'b0, b_prdy = 1'b0;
  logic [7:0]         b_len = '0;
  logic signed [21:0] b_data = '0;
  logic               b_out_pvld, b_out_sat, b_busy, b_ovf;
  logic signed [23:0] b_out_data;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_checks = 0;
  int   n_err    = 0;

  cmac_psum_accum u_dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .cfg_reg_en     (a_cfg_en),
    .cfg_accum_len  (a_len),
    .mac_out_pvld   (a_pvld),
    .mac_out_data   (a_data),
    .acc_out_pvld   (a_out_pvld),
    .acc_out_prdy   (a_prdy),
    .acc_out_data   (a_out_data),
    .acc_out_sat    (a_out_sat),
    .acc_busy       (a_busy),
    .acc_ovf_err    (a_ovf)
  );

  cmac_psum_accum #(
    .ACC_W (24)
  ) u_dut24 (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .cfg_reg_en     (b_cfg_en),
    .cfg_accum_len  (b_len),
    .mac_out_pvld   (b_pvld),
    .mac_out_data   (b_data),
    .acc_out_pvld   (b_out_pvld),
    .acc_out_prdy   (b_prdy),
    .acc_out_data   (b_out_data),
    .acc_out_sat    (b_out_sat),
    .acc_busy       (b_busy),
    .acc_ovf_err    (b_ovf)
  );

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic s, input int d);
    mk.sat  = s;
    mk.data = d;
  endfunction

  always @(negedge clk) begin
    if (a_out_pvld && a_prdy) begin
      if (q_a.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL a_unexpected: got %0d expected no result", a_out_data);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        check("a_data", a_out_data, e.data);
        check("a_sat", a_out_sat, e.sat);
      end
    end
    if (b_out_pvld && b_prdy) begin
      if (q_b.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL b_unexpected: got %0d expected no result", b_out_data);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        check("b_data", b_out_data, e.data);
        check("b_sat", b_out_sat, e.sat);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_cfg(input logic [7:0] len);
    a_cfg_en = 1'b1;
    a_len    = len;
    step();
    a_cfg_en = 1'b0;
  endtask

  task automatic a_part(input logic signed [21:0] d);
    a_pvld = 1'b1;
    a_data = d;
    step();
    a_pvld = 1'b0;
  endtask

  task automatic b_cfg(input logic [7:0] len);
    b_cfg_en = 1'b1;
    b_len    = len;
    step();
    b_cfg_en = 1'b0;
  endtask

  task automatic b_part(input logic signed [21:0] d);
    b_pvld = 1'b1;
    b_data = d;
    step();
    b_pvld = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int busy_cnt;
    int vals[5];
    vals = '{11, 22, 33, 44, 55};

    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pvld", a_out_pvld, 0);
    check("rst_data", a_out_data, 0);
    check("rst_sat", a_out_sat, 0);
    check("rst_busy", a_busy, 0);
    check("rst_ovf", a_ovf, 0);
    rst = 1'b0;
    step();

    // Length 4, basic sum
    a_cfg(3);
    a_prdy   = 1'b1;
    busy_cnt = 0;
    a_part(100);
    busy_cnt += int'(a_busy);
    a_part(-30);
    busy_cnt += int'(a_busy);
    a_part(7);
    busy_cnt += int'(a_busy);
    q_a.push_back(mk(1'b0, 78));
    a_part(1);
    busy_cnt += int'(a_busy);
    check("t1_busy_cycles", busy_cnt, 3);
    check("t1_latency_pvld", a_out_pvld, 1);
    step();

    // Length 1, extremes of the input range back to back
    a_cfg(0);
    q_a.push_back(mk(1'b0, 2097151));
    q_a.push_back(mk(1'b0, -2097152));
    a_part(22'h1FFFFF);
    check("t2_first_pvld", a_out_pvld, 1);
    a_part(22'h200000);
    check("t2_second_pvld", a_out_pvld, 1);
    check("t2_second_data", a_out_data, -2097152);
    step();

    // Overflow: consumer stalled, five results into a four-deep FIFO
    a_prdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) q_a.push_back(mk(1'b0, vals[i]));
      a_part(22'(vals[i]));
      check("t4_head_stable", a_out_data, 11);
    end
    check("t4_ovf_set", a_ovf, 1);
    a_prdy = 1'b1;
    for (int i = 0; i < 10 && a_out_pvld; i++) step();
    check("t4_drained", a_out_pvld, 0);
    check("t4_queue_empty", q_a.size(), 0);

    // Config pulse mid-accumulation discards the partial sum
    a_cfg(3);
    check("t5_ovf_clear", a_ovf, 0);
    a_part(50);
    a_part(50);
    check("t5_busy_mid", a_busy, 1);
    a_cfg_en = 1'b1;
    a_len    = 8'd3;
    a_pvld   = 1'b1;
    a_data   = 22'sd1000;
    step();
    a_cfg_en = 1'b0;
    a_pvld   = 1'b0;
    check("t5_busy_after_cfg", a_busy, 0);
    q_a.push_back(mk(1'b0, 4));
    for (int i = 0; i < 4; i++) a_part(1);
    check("t5_pvld", a_out_pvld, 1);
    step();

    // Asynchronous reset with results queued and a sum in progress
    a_prdy = 1'b0;
    a_cfg(0);
    a_part(7);
    a_part(9);
    check("t6_queued", a_out_pvld, 1);
    a_cfg(3);
    a_part(5);
    a_part(5);
    check("t6_busy", a_busy, 1);
    #3 rst = 1'b1;
    #1;
    check("t6_async_pvld", a_out_pvld, 0);
    check("t6_async_busy", a_busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    a_cfg(3);
    a_prdy = 1'b1;
    q_a.push_back(mk(1'b0, 26));
    a_part(5);
    a_part(6);
    a_part(7);
    a_part(8);
    check("t6_pvld", a_out_pvld, 1);
    step();

    // 24-bit result: positive and negative saturation, then a plain value
    b_prdy = 1'b1;
    b_cfg(15);
    q_b.push_back(mk(1'b1, 8388607));
    for (int i = 0; i < 16; i++) b_part(22'h1FFFFF);
    check("t3_pos_pvld", b_out_pvld, 1);
    step();
    q_b.push_back(mk(1'b1, -8388608));
    for (int i = 0; i < 16; i++) b_part(22'h200000);
    check("t3_neg_pvld", b_out_pvld, 1);
    step();
    b_cfg(0);
    q_b.push_back(mk(1'b0, -5));
    b_part(-5);
    step();

    repeat (3) step();
    check("end_q_a_empty", q_a.size(), 0);
    check("end_q_b_empty", q_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
